if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Fetch-side producer of the IF/ID interface in the pipelined RV32 core. It owns the PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and presents InstrFetched, PCF and PCPlus4F to the IF/ID pipeline register. It obeys StallF and branch/jump redirects from execute. While no instruction is ready it drives a NOP bubble and raises FetchBusyF to the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid fetch

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hazard unit: hold current fetch output and PC
PCSrcE  in  1  execute: redirect taken this cycle
PCTargetE  in  32  execute: redirect target
imem_req  out  1  request valid
imem_addr  out  32  request word address (= PCF)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
InstrFetched  out  32  instruction to IF/ID
PCF  out  32  PC of InstrFetched / current request
PCPlus4F  out  32  PCF + 4
FetchValidF  out  1  InstrFetched is a real instruction
FetchBusyF  out  1  stall request to hazard unit (= !FetchValidF)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Reset values: PCF=RESET_PC, state=REQ, instr_q=NOP_INSTR. During reset imem_req=0, FetchValidF=0 and InstrFetched=NOP_INSTR.
- PCF[1:0] is always 2'b00. PCTargetE[1:0] is ignored. PCPlus4F is combinational PCF+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
- InstrFetched = instr_q when FetchValidF=1, else NOP_INSTR. FetchValidF=1 only in PRESENT.
- Only one request is outstanding. imem_rvalid outside WAIT/DROP is ignored (assertion error in bench).
- States:
  - REQ:
    - imem_req = !PCSrcE; imem_addr=PCF.
    - If PCSrcE: PCF<=target, stay REQ; no request is issued that cycle.
    - Else if imem_gnt: -> WAIT.
    - Else stay REQ.
  - WAIT:
    - PCSrcE && imem_rvalid: discard data, PCF<=target, -> REQ.
    - PCSrcE && !imem_rvalid: PCF<=target, -> DROP.
    - imem_rvalid only: instr_q<=imem_rdata, -> PRESENT.
  - DROP: waits for the stale response.
    - PCSrcE: PCF<=target (latest wins).
    - On imem_rvalid: discard, -> REQ.
  - PRESENT:
    - PCSrcE: PCF<=target, -> REQ. Redirect has priority over StallF.
    - Else if StallF: hold PCF and instr_q.
    - Else: PCF<=PCF+4, -> REQ.
- Stall and the memory handshake are independent. StallF in REQ/WAIT does not block the request or the response. StallF only holds PRESENT.
- Latency: with gnt and rvalid arriving one cycle after req, an instruction presents 2 cycles after entering REQ. Throughput is 1 instruction per 3 cycles (REQ, WAIT, PRESENT). Pipelining the next request is out of scope.
- Reset mid-operation: everything returns to its reset value immediately. Any response arriving after reset deasserts, while in REQ, is ignored.

Decomposition:
- Shared package core_pkg:
  - NOP_INSTR constant.
  - RESET_PC default.
  - fetch_state_t enum {REQ, WAIT, DROP, PRESENT}, 2 bits.
- One natural sub-module, fetch_pc_reg: holds the PC register and next-PC mux (hold / +4 / target, with low-bit masking).
- The FSM and instruction buffer stay in the top module.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after each grant, rdata=32'h00500093 -> imem_addr sequence 0,4,8. FetchValidF pulses every 3rd cycle with PCF=0,4,8. PCPlus4F=4,8,12.
- StallF=1 for 4 cycles while in PRESENT at PCF=8 -> InstrFetched, PCF=8 and FetchValidF held for all 4 cycles. No imem_req. Next imem_addr=12 after StallF drops.
- PCSrcE=1, PCTargetE=32'h103 in WAIT with no rvalid -> DROP. Stale rdata discarded; FetchValidF stays 0. Next imem_addr=32'h100.
- PCSrcE=1 and imem_rvalid=1 in the same WAIT cycle, and PCSrcE=1 with StallF=1 in PRESENT -> both instructions dropped. PCF=target and the next request is issued from the target.
- imem_gnt held 0 for 5 cycles -> imem_req and imem_addr stable, FetchBusyF=1, InstrFetched=32'h00000013. Grant on cycle 6 -> WAIT.
- PCF=32'hFFFF_FFFC -> PCPlus4F=0. After PRESENT with StallF=0, the next imem_addr=0. rst_n asserted in WAIT -> PCF=RESET_PC and imem_req=0 in the same cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 fetch stage.
//   NOP_INSTR     : bubble instruction (addi x0,x0,0)
//   RESET_PC      : default PC after reset
//   fetch_state_t : fetch FSM states
//   pc_sel_t      : next-PC selector used by fetch_pc_reg
package core_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {REQ, WAIT, DROP, PRESENT} fetch_state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_TGT} pc_sel_t;

  // PCs are word addresses; the two low bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus.
//   req/addr : fetch -> memory, request valid and word address
//   gnt      : memory accepts the request this cycle
//   rvalid   : read data valid, rdata carries the instruction word
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC mux (hold / +4 / redirect target).
//   clk, rst_n : clock, async active-low reset
//   sel        : next-PC selection
//   target     : redirect target (low bits ignored)
//   pc_q       : current PC, always word aligned
//   pc_plus4   : pc_q + 4, wraps modulo 2^32
import core_pkg::*;

module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_t     sel,
  input  logic [31:0] target,
  output logic [31:0] pc_q,
  output logic [31:0] pc_plus4
);
  logic [31:0] pc_d;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INC:  pc_d = pc_plus4;
      PC_TGT:  pc_d = word_align(target);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= word_align(RESET_PC);
    else        pc_q <= pc_d;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch-side producer of the IF/ID interface.
// Issues one instruction-memory request at a time, buffers the returned
// word and presents it with its PC until decode takes it. Redirects from
// execute drop whatever is in flight; a response already in flight when a
// redirect hits is waited out in DROP and discarded.
//   clk, rst_n        : clock, async active-low reset
//   StallF            : hold the presented instruction and PC
//   PCSrcE/PCTargetE  : redirect from execute
//   imem              : request/response bus (master side)
//   InstrFetched      : instruction to IF/ID (NOP when not valid)
//   PCF, PCPlus4F     : PC of the presented instruction / request, and +4
//   FetchValidF       : InstrFetched is real
//   FetchBusyF        : stall request to the hazard unit
import core_pkg::*;

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    StallF,
  input  logic                    PCSrcE,
  input  logic [31:0]             PCTargetE,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             InstrFetched,
  output logic [31:0]             PCF,
  output logic [31:0]             PCPlus4F,
  output logic                    FetchValidF,
  output logic                    FetchBusyF
);
  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  pc_sel_t      pc_sel;
  logic         req_raw;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (pc_sel),
    .target   (PCTargetE),
    .pc_q     (PCF),
    .pc_plus4 (PCPlus4F)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_sel  = PC_HOLD;
    req_raw = 1'b0;
    case (state_q)
      REQ: begin
        // A redirect suppresses the request so the stale PC is never sent.
        req_raw = !PCSrcE;
        if (PCSrcE)             pc_sel  = PC_TGT;
        else if (imem.gnt)      state_d = WAIT;
      end
      WAIT: begin
        if (PCSrcE) begin
          pc_sel  = PC_TGT;
          state_d = imem.rvalid ? REQ : DROP;
        end else if (imem.rvalid) begin
          instr_d = imem.rdata;
          state_d = PRESENT;
        end
      end
      DROP: begin
        if (PCSrcE)      pc_sel  = PC_TGT;
        if (imem.rvalid) state_d = REQ;
      end
      PRESENT: begin
        if (PCSrcE) begin
          pc_sel  = PC_TGT;
          state_d = REQ;
        end else if (!StallF) begin
          pc_sel  = PC_INC;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Gate with rst_n so no request escapes while reset is held.
  assign imem.req     = req_raw && rst_n;
  assign imem.addr    = PCF;
  assign FetchValidF  = (state_q == PRESENT);
  assign FetchBusyF   = !FetchValidF;
  assign InstrFetched = FetchValidF ? instr_q : NOP_INSTR;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a directed vector table covering sequential
// fetch, stall, grant back-pressure, redirects and PC wrap, a hand-written
// reset sequence, then a random-handshake run scored against a queue of
// expected {PC, instruction} pairs pushed at each grant.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst_n, StallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrFetched, PCF, PCPlus4F;
  logic        FetchValidF, FetchBusyF;

  if_fetch_unit_if mem();

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem(mem), .InstrFetched(InstrFetched),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .FetchValidF(FetchValidF),
    .FetchBusyF(FetchBusyF)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        stall, src;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_vld;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string n, logic s, logic p, logic [31:0] t,
                              logic g, logic r, logic [31:0] d,
                              logic er, logic [31:0] ep, logic ev, logic [31:0] ei);
    vec_t v;
    v.name = n; v.stall = s; v.src = p; v.tgt = t; v.gnt = g; v.rv = r;
    v.rdata = d; v.e_req = er; v.e_pc = ep; v.e_vld = ev; v.e_instr = ei;
    return v;
  endfunction

  task automatic check_outs(input string n, input logic er, input logic [31:0] ep,
                            input logic ev, input logic [31:0] ei);
    logic [31:0] p4;
    p4 = ep + 32'd4;
    chk({n, ".req"},   {31'd0, mem.req},     {31'd0, er});
    chk({n, ".addr"},  mem.addr,             ep);
    chk({n, ".pcf"},   PCF,                  ep);
    chk({n, ".pc4"},   PCPlus4F,             p4);
    chk({n, ".vld"},   {31'd0, FetchValidF}, {31'd0, ev});
    chk({n, ".busy"},  {31'd0, FetchBusyF},  {31'd0, !ev});
    chk({n, ".instr"}, InstrFetched,         ei);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];

  initial begin
    rst_n = 1'b0; StallF = 0; PCSrcE = 0; PCTargetE = 0;
    mem.gnt = 0; mem.rvalid = 0; mem.rdata = 0;

    // Sequential fetch with stall at PC 8.
    tv.push_back(mk("req0",   0,0,0, 1,0,0,  1,32'h0,0,NOP));
    tv.push_back(mk("wait0",  0,0,0, 1,1,I0, 0,32'h0,0,NOP));
    tv.push_back(mk("pres0",  0,0,0, 0,0,0,  0,32'h0,1,I0));
    tv.push_back(mk("req4",   0,0,0, 1,0,0,  1,32'h4,0,NOP));
    tv.push_back(mk("wait4",  0,0,0, 0,1,I0, 0,32'h4,0,NOP));
    tv.push_back(mk("pres4",  0,0,0, 0,0,0,  0,32'h4,1,I0));
    tv.push_back(mk("req8",   0,0,0, 1,0,0,  1,32'h8,0,NOP));
    tv.push_back(mk("wait8",  0,0,0, 0,1,I0, 0,32'h8,0,NOP));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk("stall8", 1,0,0, 1,0,0, 0,32'h8,1,I0));
    tv.push_back(mk("unstall",0,0,0, 0,0,0,  0,32'h8,1,I0));
    // Grant withheld for 5 cycles.
    for (int i = 0; i < 5; i++)
      tv.push_back(mk("nognt12",0,0,0, 0,0,0, 1,32'hC,0,NOP));
    tv.push_back(mk("gnt12",  0,0,0, 1,0,0,  1,32'hC,0,NOP));
    // Redirect in WAIT before the response -> DROP the stale word.
    tv.push_back(mk("redir_w",0,1,32'h103, 0,0,0, 0,32'hC,0,NOP));
    tv.push_back(mk("drop",   0,0,0, 0,1,32'hDEADBEEF, 0,32'h100,0,NOP));
    tv.push_back(mk("req100", 0,0,0, 1,0,0,  1,32'h100,0,NOP));
    // Redirect coincident with the response.
    tv.push_back(mk("redir_rv",0,1,32'h200, 0,1,32'hBAD00013, 0,32'h100,0,NOP));
    tv.push_back(mk("req200", 0,0,0, 1,0,0,  1,32'h200,0,NOP));
    tv.push_back(mk("wait200",0,0,0, 0,1,32'h11111113, 0,32'h200,0,NOP));
    // Redirect beats stall in PRESENT.
    tv.push_back(mk("redir_st",1,1,32'h300, 0,0,0, 0,32'h200,1,32'h11111113));
    // Redirect in REQ suppresses the request even with gnt.
    tv.push_back(mk("redir_rq",0,1,32'hFFFFFFFF, 1,0,0, 0,32'h300,0,NOP));
    tv.push_back(mk("req_top",0,0,0, 1,0,0,  1,32'hFFFFFFFC,0,NOP));
    tv.push_back(mk("wait_top",0,0,0,0,1,32'h22222213, 0,32'hFFFFFFFC,0,NOP));
    tv.push_back(mk("pres_top",0,0,0,0,0,0,  0,32'hFFFFFFFC,1,32'h22222213));
    tv.push_back(mk("req_wrap",0,0,0,1,0,0,  1,32'h0,0,NOP));
    tv.push_back(mk("wait0b", 0,0,0, 0,1,32'h33333313, 0,32'h0,0,NOP));
    tv.push_back(mk("pres0b", 0,0,0, 0,0,0,  0,32'h0,1,32'h33333313));
    tv.push_back(mk("req4b",  0,0,0, 1,0,0,  1,32'h4,0,NOP));

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1 check_outs("rst", 0, 32'h0, 0, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      StallF = tv[i].stall; PCSrcE = tv[i].src; PCTargetE = tv[i].tgt;
      mem.gnt = tv[i].gnt; mem.rvalid = tv[i].rv; mem.rdata = tv[i].rdata;
      #1 check_outs(tv[i].name, tv[i].e_req, tv[i].e_pc, tv[i].e_vld, tv[i].e_instr);
    end

    // Now in WAIT at PC 4: reset takes effect immediately.
    @(negedge clk);
    StallF = 0; PCSrcE = 0; mem.gnt = 0; mem.rvalid = 0;
    #1 check_outs("pre_rst", 0, 32'h4, 0, NOP);
    rst_n = 1'b0;
    #1 check_outs("mid_rst", 0, 32'h0, 0, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    // Late response arriving in REQ must be ignored.
    mem.rvalid = 1; mem.rdata = 32'hCAFE0013;
    #1 check_outs("late_rv", 1, 32'h0, 0, NOP);
    @(negedge clk);
    mem.rvalid = 0;
    #1 check_outs("late_rv2", 1, 32'h0, 0, NOP);

    // Random handshake run with scoreboard.
    begin
      bit          outst = 0;
      bit          rv;
      bit          prev_v = 0;
      int          dly = 0;
      int          seen = 0;
      logic [31:0] pend = 0;
      logic [31:0] exp_next = 0;
      exp_t        e;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        rv = outst && (dly == 0);
        mem.rvalid = rv;
        mem.rdata  = rv ? mem_word(pend) : $urandom;
        mem.gnt    = ($urandom_range(0, 2) != 0);
        StallF     = ($urandom_range(0, 3) == 0);
        PCSrcE     = 0;
        PCTargetE  = $urandom;
        #1;
        if (rv) outst = 0;
        else if (outst) dly--;
        if (mem.req && mem.gnt) begin
          chk("rnd.addr", mem.addr, exp_next);
          outst = 1;
          dly   = $urandom_range(0, 2);
          pend  = mem.addr;
          e.pc = mem.addr; e.instr = mem_word(mem.addr);
          sb.push_back(e);
        end
        if (FetchValidF && !prev_v) begin
          if (sb.size() == 0) begin
            chk("rnd.sb_empty", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            chk("rnd.pcf",   PCF,          e.pc);
            chk("rnd.instr", InstrFetched, e.instr);
            chk("rnd.pc4",   PCPlus4F,     e.pc + 32'd4);
            exp_next = e.pc + 32'd4;
            seen++;
          end
        end
        prev_v = FetchValidF;
      end
      // Starvation check: the random run must have delivered instructions.
      chk("rnd.progress", {31'd0, seen > 50}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
